mips_regfile_mp: RTL and testbench
==================================

// Module: mips_regfile_mp
// PURPOSE
//  Parametrised multi-port general-purpose register file for the MIPS core, replacing the fixed 2R/1W
//  32x32 file. Adds N read / M write ports, write-through bypass and a per-register scoreboard
//  (pending bits), so decode can stall on outstanding producers.
//  Sits between decode (reads, allocs) and writeback (writes). Flush comes from the hazard unit.
// PARAMETERS
//  DATA_W     32  register width in bits
//  NUM_REGS   32  register count, power of 2 >= 2; AW = $clog2(NUM_REGS)
//  NUM_RD      2  read ports, 1..4
//  NUM_WR      1  write ports, 1..2
//  ZERO_REG    1  1: register 0 reads 0, writes and allocs to it are ignored
//  BYPASS      1  1: same-cycle write data is forwarded to matching read ports
// PORTS
//  clock__i       in   1               core clock; all state updates on posedge
//  rst_n__i       in   1               reset, asynchronous, active-low
//  Wr_En__i       in   NUM_WR          per-port write enable
//  Wr_Addr__i     in   NUM_WR*AW       write addresses, port p at [p*AW +: AW]
//  Wr_Data__i     in   NUM_WR*DATA_W   write data, port p at [p*DATA_W +: DATA_W]
//  Rd_Addr__i     in   NUM_RD*AW       read addresses
//  Rd_Data__o     out  NUM_RD*DATA_W   read data, combinational
//  Rd_Ready__o    out  NUM_RD          1 = register has no outstanding producer
//  Alloc_En__i    in   1               mark Alloc_Addr__i pending (instruction issued)
//  Alloc_Addr__i  in   AW              destination register being allocated
//  Flush__i       in   1               clear every pending bit
//  Pending__o     out  NUM_REGS        scoreboard state, registered
// BEHAVIOUR
//  Reset (async assert): all registers <= 0, all pending <= 0. Pending__o = 0 and Rd_Ready__o = all 1.
//    Rd_Data__o = 0 for every address while in reset and until the first write.
//  Write: on posedge, each enabled port writes its register. Write latency is 1 cycle.
//    Two ports writing the same address in one cycle: the higher port index wins.
//  Read, combinational:
//    - ZERO_REG=1 and Rd_Addr=0 -> data 0, ready 1.
//    - Else, BYPASS=1 and an enabled write port matches the address -> that port's Wr_Data, ready 1.
//      Highest matching port index wins.
//    - Else -> stored value; ready = !pending[addr].
//    - BYPASS=0: reads return the stored value only. New data is visible the cycle after the write.
//  Scoreboard, per register r, evaluated at posedge:
//    - Flush__i: pending <= 0 for all r. Any alloc in the same cycle is dropped.
//    - Else Alloc_En__i && Alloc_Addr==r -> pending[r] <= 1.
//      Alloc wins over a same-cycle write to r, because that write comes from an older producer.
//    - Else any write to r -> pending[r] <= 0.
//    - ZERO_REG=1: pending[0] is held at 0.
//  Writes to a non-pending register are legal. Data updates; pending stays 0.
//  Address width: every address is exactly AW bits, so there are no out-of-range addresses.
//  Reset asserted mid-operation: state clears immediately. Writes and allocs in flight are lost.
//  No handshakes. The block never stalls; decode consumes Rd_Ready__o.
// STRUCTURE
//  Package mips_regfile_pkg:
//    - default constants DATA_W_DEF, NUM_REGS_DEF
//    - typedef reg_addr_t = logic [AW-1:0]
//    - function sel_wr_port(): highest-index address-match priority encoder, shared by write and bypass
//  Sub-module mips_regfile_scoreboard (NUM_REGS, ZERO_REG):
//    - holds the pending vector and the flush/alloc/clear logic
//    - exports Pending__o
//    - combinational lookup of pending bits for the read ports
//  Top level: storage array, write-priority resolution, read/bypass muxes.
// TESTING
//  1. Reset, then read all 32 addresses -> data 0, ready 1, Pending__o = 0.
//  2. Write r5=0xDEADBEEF on port 0 while reading r5, BYPASS=1:
//     same cycle -> 0xDEADBEEF, ready 1; next cycle -> stored 0xDEADBEEF.
//     With BYPASS=0, the same-cycle read returns 0.
//  3. NUM_WR=2, both ports write r7, port0=0x1 and port1=0x2 -> r7 reads 0x2.
//     Write r0=0xFFFF -> r0 reads 0.
//  4. Alloc r9 -> Pending__o[9]=1 next cycle, read r9 ready 0.
//     Write r9=0x55 -> that cycle ready 1 with data 0x55; next cycle pending 0.
//  5. Same cycle: alloc r3 and write r3=0xA -> r3 = 0xA, pending[3] = 1.
//     Then flush together with alloc r4 -> Pending__o = 0.
//  6. Assert rst_n__i low mid-cycle after writes r1..r4 and alloc r6 -> all data 0 and pending 0
//     immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_regfile_pkg.sv
// Shared constants, types and the write-port priority encoder for the multi-port register file.
package mips_regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned AW_DEF       = $clog2(NUM_REGS_DEF);
  localparam int unsigned MAX_WR       = 2;
  localparam int unsigned WR_IDX_W     = $clog2(MAX_WR);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] idx;
  } wr_sel_t;

  // Later ports overwrite earlier ones, so the highest matching index wins.
  function automatic wr_sel_t sel_wr_port(input logic [MAX_WR-1:0] match);
    wr_sel_t sel;
    sel = '0;
    for (int p = 0; p < MAX_WR; p++) begin
      if (match[p]) begin
        sel.hit = 1'b1;
        sel.idx = p[WR_IDX_W-1:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mips_regfile_if.sv
// Decode/writeback-facing bus of the register file: write ports, read ports and scoreboard.
interface mips_regfile_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [NUM_WR-1:0]        Wr_En__i;
  logic [NUM_WR*AW-1:0]     Wr_Addr__i;
  logic [NUM_WR*DATA_W-1:0] Wr_Data__i;
  logic [NUM_RD*AW-1:0]     Rd_Addr__i;
  logic [NUM_RD*DATA_W-1:0] Rd_Data__o;
  logic [NUM_RD-1:0]        Rd_Ready__o;
  logic                     Alloc_En__i;
  logic [AW-1:0]            Alloc_Addr__i;
  logic                     Flush__i;
  logic [NUM_REGS-1:0]      Pending__o;

  modport master (
    output Wr_En__i, Wr_Addr__i, Wr_Data__i, Rd_Addr__i, Alloc_En__i, Alloc_Addr__i, Flush__i,
    input  Rd_Data__o, Rd_Ready__o, Pending__o
  );

  modport slave (
    input  Wr_En__i, Wr_Addr__i, Wr_Data__i, Rd_Addr__i, Alloc_En__i, Alloc_Addr__i, Flush__i,
    output Rd_Data__o, Rd_Ready__o, Pending__o
  );

endinterface

// File: rtl/mips_regfile_scoreboard.sv
// Per-register pending bits: set on alloc, cleared by writeback or flush, looked up per read port.
module mips_regfile_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned NUM_RD   = 2,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                 clock__i,
  input  logic                 rst_n__i,
  input  logic                 i_alloc_en,
  input  logic [AW-1:0]        i_alloc_addr,
  input  logic                 i_flush,
  input  logic [NUM_REGS-1:0]  i_wr_hit,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]    o_rd_pending,
  output logic [NUM_REGS-1:0]  o_pending
);

  logic [NUM_REGS-1:0] r_pending;

  // Alloc beats a same-cycle write: the write belongs to an older producer.
  always_ff @(posedge clock__i or negedge rst_n__i) begin
    if (!rst_n__i) begin
      r_pending <= '0;
    end else if (i_flush) begin
      r_pending <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (ZERO_REG != 0 && r == 0) begin
          r_pending[r] <= 1'b0;
        end else if (i_alloc_en && i_alloc_addr == AW'(r)) begin
          r_pending[r] <= 1'b1;
        end else if (i_wr_hit[r]) begin
          r_pending[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_rd_pending = '0;
    for (int q = 0; q < NUM_RD; q++) begin
      o_rd_pending[q] = r_pending[i_rd_addr[q*AW +: AW]];
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port GPR file: storage, write-priority resolution and read/bypass muxing.
module mips_regfile_mp
  import mips_regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic          clock__i,
  input logic          rst_n__i,
  mips_regfile_if.slave bus
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  wr_sel_t             w_wsel [NUM_REGS];
  logic [NUM_REGS-1:0] w_wr_hit;
  logic [NUM_RD-1:0]   w_rd_pending;

  always_comb begin
    logic [MAX_WR-1:0] v_match;
    w_wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      v_match = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        v_match[p] = bus.Wr_En__i[p] && (bus.Wr_Addr__i[p*AW +: AW] == AW'(r));
      end
      w_wsel[r]   = sel_wr_port(v_match);
      w_wr_hit[r] = w_wsel[r].hit;
    end
  end

  always_ff @(posedge clock__i or negedge rst_n__i) begin
    if (!rst_n__i) begin
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_wsel[r].hit && !(ZERO_REG != 0 && r == 0)) begin
          r_regs[r] <= bus.Wr_Data__i[int'(w_wsel[r].idx)*DATA_W +: DATA_W];
        end
      end
    end
  end

  mips_regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .NUM_RD   (NUM_RD)
  ) u_scoreboard (
    .clock__i     (clock__i),
    .rst_n__i     (rst_n__i),
    .i_alloc_en   (bus.Alloc_En__i),
    .i_alloc_addr (bus.Alloc_Addr__i),
    .i_flush      (bus.Flush__i),
    .i_wr_hit     (w_wr_hit),
    .i_rd_addr    (bus.Rd_Addr__i),
    .o_rd_pending (w_rd_pending),
    .o_pending    (bus.Pending__o)
  );

  // A bypassed read is always ready: the producer is delivering its value this cycle.
  always_comb begin
    logic [AW-1:0]     v_addr;
    logic [MAX_WR-1:0] v_match;
    wr_sel_t           v_sel;
    bus.Rd_Data__o  = '0;
    bus.Rd_Ready__o = '0;
    for (int q = 0; q < NUM_RD; q++) begin
      v_addr  = bus.Rd_Addr__i[q*AW +: AW];
      v_match = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        v_match[p] = (BYPASS != 0) && bus.Wr_En__i[p] && (bus.Wr_Addr__i[p*AW +: AW] == v_addr);
      end
      v_sel = sel_wr_port(v_match);
      if (ZERO_REG != 0 && v_addr == '0) begin
        bus.Rd_Data__o[q*DATA_W +: DATA_W] = '0;
        bus.Rd_Ready__o[q]                 = 1'b1;
      end else if (v_sel.hit) begin
        bus.Rd_Data__o[q*DATA_W +: DATA_W] = bus.Wr_Data__i[int'(v_sel.idx)*DATA_W +: DATA_W];
        bus.Rd_Ready__o[q]                 = 1'b1;
      end else begin
        bus.Rd_Data__o[q*DATA_W +: DATA_W] = r_regs[v_addr];
        bus.Rd_Ready__o[q]                 = !w_rd_pending[q];
      end
    end
  end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares them.
module tb_mips_regfile_mp;
  import mips_regfile_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: two write ports with bypass; shadow DUT: one write port, no bypass.
  mips_regfile_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) bus_a ();
  mips_regfile_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1)) bus_b ();

  mips_regfile_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut_a (
    .clock__i (clk),
    .rst_n__i (rst_n),
    .bus      (bus_a.slave)
  );

  mips_regfile_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)
  ) u_dut_b (
    .clock__i (clk),
    .rst_n__i (rst_n),
    .bus      (bus_b.slave)
  );

  assign bus_b.Wr_En__i      = bus_a.Wr_En__i[0];
  assign bus_b.Wr_Addr__i    = bus_a.Wr_Addr__i[4:0];
  assign bus_b.Wr_Data__i    = bus_a.Wr_Data__i[31:0];
  assign bus_b.Rd_Addr__i    = bus_a.Rd_Addr__i;
  assign bus_b.Alloc_En__i   = bus_a.Alloc_En__i;
  assign bus_b.Alloc_Addr__i = bus_a.Alloc_Addr__i;
  assign bus_b.Flush__i      = bus_a.Flush__i;

  localparam int SelRd0   = 0;
  localparam int SelRd1   = 1;
  localparam int SelReady = 2;
  localparam int SelPend  = 3;
  localparam int SelRdB   = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests;
  int   n_fail;

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    q_exp.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SelRd0:   return bus_a.Rd_Data__o[31:0];
      SelRd1:   return bus_a.Rd_Data__o[63:32];
      SelReady: return {30'b0, bus_a.Rd_Ready__o};
      SelPend:  return bus_a.Pending__o;
      default:  return bus_b.Rd_Data__o[31:0];
    endcase
  endfunction

  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = q_exp.pop_front();
      act = actual(e.sel);
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.Wr_En__i    = '0;
    bus_a.Wr_Addr__i  = '0;
    bus_a.Wr_Data__i  = '0;
    bus_a.Alloc_En__i = 1'b0;
    bus_a.Alloc_Addr__i = '0;
    bus_a.Flush__i    = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus_a.Rd_Addr__i = {a1, a0};
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    bus_a.Wr_En__i[0]        = 1'b1;
    bus_a.Wr_Addr__i[4:0]    = a;
    bus_a.Wr_Data__i[31:0]   = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    set_rd(5'd5, 5'd0);

    step();
    expect_val("in_reset_rd0", SelRd0, 32'h0);
    expect_val("in_reset_ready", SelReady, 32'h3);
    expect_val("in_reset_pending", SelPend, 32'h0);
    step();
    rst_n = 1'b1;

    // Every address reads 0 and ready after reset.
    for (int a = 0; a < 32; a++) begin
      step();
      set_rd(5'(a), 5'(31 - a));
      expect_val($sformatf("reset_rd0_r%0d", a), SelRd0, 32'h0);
      expect_val($sformatf("reset_rd1_r%0d", 31 - a), SelRd1, 32'h0);
      expect_val($sformatf("reset_ready_%0d", a), SelReady, 32'h3);
      expect_val($sformatf("reset_pend_%0d", a), SelPend, 32'h0);
    end

    // Write r5 with same-cycle read: bypass vs stored.
    step();
    set_rd(5'd5, 5'd0);
    wr0(5'd5, 32'hDEAD_BEEF);
    expect_val("bypass_r5", SelRd0, 32'hDEAD_BEEF);
    expect_val("bypass_r5_ready", SelReady, 32'h3);
    expect_val("nobypass_r5_same", SelRdB, 32'h0);
    step();
    idle_inputs();
    expect_val("stored_r5", SelRd0, 32'hDEAD_BEEF);
    expect_val("nobypass_r5_next", SelRdB, 32'hDEAD_BEEF);

    // Dual write to r7: port 1 wins, in bypass and in storage.
    step();
    set_rd(5'd7, 5'd0);
    bus_a.Wr_En__i   = 2'b11;
    bus_a.Wr_Addr__i = {5'd7, 5'd7};
    bus_a.Wr_Data__i = {32'h2, 32'h1};
    expect_val("dual_wr_bypass_r7", SelRd0, 32'h2);
    step();
    idle_inputs();
    expect_val("dual_wr_stored_r7", SelRd0, 32'h2);

    // r0 is hardwired.
    step();
    set_rd(5'd0, 5'd0);
    wr0(5'd0, 32'h0000_FFFF);
    expect_val("r0_same", SelRd0, 32'h0);
    step();
    idle_inputs();
    expect_val("r0_next", SelRd0, 32'h0);
    expect_val("r0_next_b", SelRdB, 32'h0);

    // Alloc r9, then its producer writes back.
    step();
    set_rd(5'd9, 5'd0);
    bus_a.Alloc_En__i   = 1'b1;
    bus_a.Alloc_Addr__i = 5'd9;
    expect_val("alloc_r9_same_pend", SelPend, 32'h0);
    expect_val("alloc_r9_same_ready", SelReady, 32'h3);
    step();
    idle_inputs();
    expect_val("alloc_r9_pend", SelPend, 32'h0000_0200);
    expect_val("alloc_r9_ready", SelReady, 32'h2);
    step();
    wr0(5'd9, 32'h55);
    expect_val("wb_r9_data", SelRd0, 32'h55);
    expect_val("wb_r9_ready", SelReady, 32'h3);
    expect_val("wb_r9_pend_same", SelPend, 32'h0000_0200);
    step();
    idle_inputs();
    expect_val("wb_r9_pend_next", SelPend, 32'h0);
    expect_val("wb_r9_stored", SelRd0, 32'h55);
    expect_val("wb_r9_ready_next", SelReady, 32'h3);

    // Alloc and write r3 together: data lands, alloc keeps it pending.
    step();
    set_rd(5'd3, 5'd0);
    wr0(5'd3, 32'hA);
    bus_a.Alloc_En__i   = 1'b1;
    bus_a.Alloc_Addr__i = 5'd3;
    expect_val("alloc_wr_r3_bypass", SelRd0, 32'hA);
    step();
    idle_inputs();
    expect_val("alloc_wr_r3_data", SelRd0, 32'hA);
    expect_val("alloc_wr_r3_pend", SelPend, 32'h0000_0008);
    expect_val("alloc_wr_r3_ready", SelReady, 32'h2);

    // Flush drops a same-cycle alloc.
    step();
    bus_a.Flush__i      = 1'b1;
    bus_a.Alloc_En__i   = 1'b1;
    bus_a.Alloc_Addr__i = 5'd4;
    expect_val("flush_same_pend", SelPend, 32'h0000_0008);
    step();
    idle_inputs();
    expect_val("flush_pend", SelPend, 32'h0);
    expect_val("flush_ready", SelReady, 32'h3);

    // Alloc of r0 is ignored.
    step();
    bus_a.Alloc_En__i   = 1'b1;
    bus_a.Alloc_Addr__i = 5'd0;
    step();
    idle_inputs();
    expect_val("alloc_r0_pend", SelPend, 32'h0);

    // Writes r1..r4, alloc r6, then async reset mid-cycle.
    for (int i = 1; i <= 4; i++) begin
      step();
      idle_inputs();
      wr0(5'(i), 32'(i));
      if (i == 4) begin
        bus_a.Alloc_En__i   = 1'b1;
        bus_a.Alloc_Addr__i = 5'd6;
      end
    end
    step();
    idle_inputs();
    set_rd(5'd1, 5'd4);
    expect_val("pre_rst_r1", SelRd0, 32'h1);
    expect_val("pre_rst_r4", SelRd1, 32'h4);
    expect_val("pre_rst_pend", SelPend, 32'h0000_0040);
    step();
    set_rd(5'd2, 5'd4);
    rst_n = 1'b0;
    expect_val("async_rst_r2", SelRd0, 32'h0);
    expect_val("async_rst_r4", SelRd1, 32'h0);
    expect_val("async_rst_pend", SelPend, 32'h0);
    expect_val("async_rst_ready", SelReady, 32'h3);
    expect_val("async_rst_r2_b", SelRdB, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    set_rd(5'd6, 5'd1);
    expect_val("post_rst_ready", SelReady, 32'h3);
    expect_val("post_rst_r1", SelRd1, 32'h0);

    step();
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued expected 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
